// File: rtl/gcd_job_scheduler.sv
// rtl/gcd_job_scheduler.sv - round-robin scheduler sharing one sequential GCD engine
// Zero operands short-circuit locally; a watchdog aborts jobs the engine never finishes.
module gcd_job_scheduler #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                     csi_clk,
  input  logic                     rsi_reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [N_REQ*W-1:0]       rsp_data,
  output logic [N_REQ-1:0]         rsp_err,
  output logic                     eng_start,
  output logic [W-1:0]             eng_a,
  output logic [W-1:0]             eng_b,
  output logic                     eng_abort,
  input  logic                     eng_done,
  input  logic [W-1:0]             eng_result,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               eng_start_q, eng_start_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0]   rsp_err_q, rsp_err_d;
  logic [N_REQ*W-1:0] rsp_data_q, rsp_data_d;

  logic               grant_found;
  logic [IW-1:0]      grant_idx, cand;
  logic [W-1:0]       sel_a, sel_b;
  logic               expired;

  // Search starts just after the last served port, so that port has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(rr_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign sel_a = req_a[grant_idx*W +: W];
  assign sel_b = req_b[grant_idx*W +: W];

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found && !rsi_reset) req_ready[grant_idx] = 1'b1;
  end

  // Abort cannot be registered: a completion in the expiry cycle must suppress it.
  assign expired   = (timer_q == TW'(TIMEOUT - 1));
  assign eng_abort = (state_q == S_WAIT) && expired && !eng_done;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    timer_d     = timer_q;
    eng_start_d = 1'b0;
    rsp_valid_d = '0;
    rsp_err_d   = '0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          owner_d = grant_idx;
          a_d     = sel_a;
          b_d     = sel_b;
          if (sel_a == '0 || sel_b == '0) begin
            state_d                      = S_RESP;
            rsp_valid_d[grant_idx]       = 1'b1;
            rsp_data_d[grant_idx*W +: W] = sel_a | sel_b;
          end else begin
            state_d     = S_ISSUE;
            eng_start_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (eng_done) begin
          state_d                    = S_RESP;
          rsp_valid_d[owner_q]       = 1'b1;
          rsp_data_d[owner_q*W +: W] = eng_result;
        end else if (expired) begin
          state_d                    = S_RESP;
          rsp_valid_d[owner_q]       = 1'b1;
          rsp_err_d[owner_q]         = 1'b1;
          rsp_data_d[owner_q*W +: W] = '0;
        end
      end
      S_RESP: begin
        rr_d    = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q     <= S_IDLE;
      rr_q        <= IW'(N_REQ - 1);
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      timer_q     <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      timer_q     <= timer_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign eng_start = eng_start_q;
  assign eng_a     = a_q;
  assign eng_b     = b_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// tb/tb_gcd_job_scheduler.sv - self-checking bench for gcd_job_scheduler
// Engine model answers eng_start after eng_lat cycles (0 = never); scoreboard checks routing and timing.
`timescale 1ns/1ps
module tb_gcd_job_scheduler;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           csi_clk = 1'b0;
  logic           rsi_reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready, rsp_valid, rsp_err;
  logic [N*W-1:0] rsp_data;
  logic           eng_start, eng_abort, busy;
  logic [W-1:0]   eng_a, eng_b;
  logic           eng_done = 1'b0;
  logic [W-1:0]   eng_result = '0;
  logic [1:0]     owner;

  gcd_job_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .csi_clk(csi_clk), .rsi_reset(rsi_reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_abort(eng_abort),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy), .owner(owner)
  );

  always #5 csi_clk = ~csi_clk;

  function automatic logic [W-1:0] gcd(logic [W-1:0] x, logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  int           eng_lat = 5;
  int           eng_cnt = 0;
  int           mcyc = 0;
  int           inject_cyc = -1;
  logic [W-1:0] eng_res = '0;
  logic [W-1:0] inject_val = '0;

  always begin
    @(posedge csi_clk); #1;
    mcyc++;
    eng_done = 1'b0;
    if (eng_start) begin
      eng_cnt = eng_lat;
      eng_res = gcd(eng_a, eng_b);
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done   = 1'b1;
        eng_result = eng_res;
      end
    end
    if (mcyc == inject_cyc) begin
      eng_done   = 1'b1;
      eng_result = inject_val;
    end
  end

  typedef struct {
    int           port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         err;
    int           acc_cyc;
    int           rsp_cyc;
  } exp_t;

  typedef struct {
    int           port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] exp_data;
    logic         exp_err;
    int           exp_starts;
    int           exp_aborts;
  } vec_t;

  exp_t         sb[$];
  int           grant_log[$];
  int           errors = 0, checks = 0;
  int           tcyc = 0, n_start = 0, n_abort = 0, n_rsp = 0, start_cyc = 0;
  logic [W-1:0] op_a[N], op_b[N], pend_data[N], last_data[N];
  logic         pend_err[N];
  logic [N-1:0] acc_mask, done_mask;
  bit           auto_mode = 1'b0;
  int           auto_left = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  task automatic drive_req(int p, logic [W-1:0] a, logic [W-1:0] b);
    op_a[p] = a;
    op_b[p] = b;
    req_a[p*W +: W] = a;
    req_b[p*W +: W] = b;
    req_valid[p] = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    tcyc++;
    acc_mask  = '0;
    done_mask = '0;
    if (req_ready != '0) begin
      chk("ready_onehot", {63'd0, $onehot(req_ready)}, 64'd1);
      chk("ready_in_valid", {60'd0, req_ready & ~req_valid}, 64'd0);
    end
    for (int p = 0; p < N; p++) begin
      if (req_valid[p] && req_ready[p]) begin
        e.port = p; e.a = op_a[p]; e.b = op_b[p];
        e.data = pend_data[p]; e.err = pend_err[p]; e.acc_cyc = tcyc;
        if (e.a == 0 || e.b == 0) e.rsp_cyc = tcyc + 1;
        else if (eng_lat == 0 || eng_lat > TO) e.rsp_cyc = tcyc + TO + 2;
        else e.rsp_cyc = tcyc + 2 + eng_lat;
        sb.push_back(e);
        grant_log.push_back(p);
        acc_mask[p] = 1'b1;
      end
    end
    if (eng_start) begin
      n_start++;
      start_cyc = tcyc;
      if (sb.size() == 0) chk("start_without_job", 64'd1, 64'd0);
      else begin
        chk("eng_start_cycle", tcyc, sb[0].acc_cyc + 1);
        chk("eng_a", eng_a, sb[0].a);
        chk("eng_b", eng_b, sb[0].b);
      end
    end
    if (eng_abort) begin
      n_abort++;
      chk("abort_after_start", tcyc - start_cyc, TO);
    end
    for (int p = 0; p < N; p++) begin
      if (rsp_valid[p]) begin
        n_rsp++;
        done_mask[p] = 1'b1;
        if (sb.size() == 0) chk("unexpected_rsp_port", p, 64'hFF);
        else begin
          e = sb.pop_front();
          chk("rsp_port", p, e.port);
          chk("rsp_data", rsp_data[p*W +: W], e.data);
          chk("rsp_err", rsp_err[p], e.err);
          chk("rsp_cycle", tcyc, e.rsp_cyc);
          last_data[e.port] = e.data;
        end
      end
    end
  endtask

  task automatic tick();
    logic [W-1:0] a, b;
    @(negedge csi_clk);
    monitor();
    @(posedge csi_clk); #1;
    for (int p = 0; p < N; p++) if (acc_mask[p]) req_valid[p] = 1'b0;
    if (auto_mode) begin
      for (int p = 0; p < N; p++) begin
        if (done_mask[p] && auto_left > 0) begin
          auto_left--;
          a = $urandom_range(1, 5000);
          b = $urandom_range(1, 5000);
          pend_data[p] = gcd(a, b);
          pend_err[p]  = 1'b0;
          drive_req(p, a, b);
        end
      end
    end
  endtask

  task automatic wait_rsp(int target, int budget, string name);
    int k = 0;
    while (n_rsp < target && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (n_rsp < target) begin
      errors++;
      $display("FAIL %s: timed out with %0d responses, needed %0d", name, n_rsp, target);
    end
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_data_lo"}, rsp_data[63:0], 0);
    chk({tag, "_rsp_data_hi"}, rsp_data[127:64], 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_abort"}, eng_abort, 0);
    chk({tag, "_eng_ab"}, {eng_a, eng_b}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vec_t vec[10];
    int   s0, a0, r0, g0, k;
    vec[0] = '{1, 48, 18, 5, 6, 0, 1, 0};
    vec[1] = '{2, 0, 7, 5, 7, 0, 0, 0};
    vec[2] = '{2, 0, 0, 5, 0, 0, 0, 0};
    vec[3] = '{3, 35, 0, 5, 35, 0, 0, 0};
    vec[4] = '{0, 17, 13, 3, 1, 0, 1, 0};
    vec[5] = '{3, 100, 75, 1, 25, 0, 1, 0};
    vec[6] = '{0, 1071, 462, 16, 21, 0, 1, 0};
    vec[7] = '{2, 81, 27, 17, 0, 1, 1, 1};
    vec[8] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 0, 1, 0};
    vec[9] = '{3, 1, 1, 1, 1, 0, 1, 0};
    for (int p = 0; p < N; p++) begin
      op_a[p] = '0; op_b[p] = '0; pend_data[p] = '0; pend_err[p] = 1'b0; last_data[p] = '0;
    end

    #1 rsi_reset = 1'b1;
    @(negedge csi_clk);
    check_all_zero("reset");
    @(posedge csi_clk); #1;
    rsi_reset = 1'b0;

    // Fairness: all ports request together and re-request after their own response.
    eng_lat = 3;
    g0 = grant_log.size();
    r0 = n_rsp;
    for (int p = 0; p < N; p++) begin
      op_a[p] = $urandom_range(1, 5000);
      op_b[p] = $urandom_range(1, 5000);
      pend_data[p] = gcd(op_a[p], op_b[p]);
      pend_err[p]  = 1'b0;
      drive_req(p, op_a[p], op_b[p]);
    end
    auto_mode = 1'b1;
    auto_left = N;
    wait_rsp(r0 + 2 * N, 400, "fairness");
    auto_mode = 1'b0;
    repeat (2) tick();
    chk("fair_grant_count", grant_log.size() - g0, 2 * N);
    if (grant_log.size() - g0 == 2 * N)
      for (int i = 0; i < 2 * N; i++) chk("fair_grant_order", grant_log[g0 + i], i % N);

    for (int i = 0; i < 10; i++) begin
      v = vec[i];
      eng_lat = v.lat;
      s0 = n_start; a0 = n_abort; r0 = n_rsp;
      pend_data[v.port] = v.exp_data;
      pend_err[v.port]  = v.exp_err;
      drive_req(v.port, v.a, v.b);
      wait_rsp(r0 + 1, 60, "vector_rsp");
      repeat (3) tick();
      chk("vec_busy_idle", busy, 0);
      chk("vec_owner", owner, v.port);
      chk("vec_starts", n_start - s0, v.exp_starts);
      chk("vec_aborts", n_abort - a0, v.exp_aborts);
      chk("vec_rsp_count", n_rsp - r0, 1);
      for (int q = 0; q < N; q++) chk("vec_rsp_data_hold", rsp_data[q*W +: W], last_data[q]);
    end

    // Engine never answers: abort, error response, then a late done must be ignored.
    eng_lat = 0;
    a0 = n_abort;
    r0 = n_rsp;
    pend_data[1] = '0;
    pend_err[1]  = 1'b1;
    drive_req(1, 12, 8);
    wait_rsp(r0 + 1, 60, "timeout_rsp");
    chk("timeout_abort_count", n_abort - a0, 1);
    inject_val = 4;
    inject_cyc = mcyc + 2;
    repeat (5) tick();
    chk("late_done_no_rsp", n_rsp - r0, 1);
    chk("late_done_busy", busy, 0);
    chk("late_done_data", rsp_data[1*W +: W], 0);

    // Reset in the middle of WAIT.
    s0 = n_start;
    pend_data[3] = '0;
    pend_err[3]  = 1'b1;
    drive_req(3, 9, 6);
    k = 0;
    while (n_start == s0 && k < 10) begin
      tick();
      k++;
    end
    chk("midwait_started", n_start - s0, 1);
    repeat (4) tick();
    chk("midwait_busy", busy, 1);
    req_valid = '0;
    rsi_reset = 1'b1;
    #1;
    check_all_zero("midwait_reset");
    sb.delete();
    for (int q = 0; q < N; q++) last_data[q] = '0;
    tick();
    rsi_reset = 1'b0;
    r0 = n_rsp;
    inject_val = 5;
    inject_cyc = mcyc + 2;
    repeat (5) tick();
    chk("stale_done_no_rsp", n_rsp - r0, 0);
    chk("stale_done_busy", busy, 0);

    eng_lat = 2;
    g0 = grant_log.size();
    pend_data[0] = 12; pend_err[0] = 1'b0;
    pend_data[1] = 7;  pend_err[1] = 1'b0;
    drive_req(0, 24, 36);
    drive_req(1, 14, 21);
    wait_rsp(r0 + 2, 60, "post_reset_rsp");
    repeat (2) tick();
    chk("post_reset_grants", grant_log.size() - g0, 2);
    if (grant_log.size() - g0 == 2) begin
      chk("post_reset_first", grant_log[g0], 0);
      chk("post_reset_second", grant_log[g0 + 1], 1);
    end
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gcd_job_scheduler.md
Name: gcd_job_scheduler

Overview:
Round-robin scheduler that shares one sequential GCD engine among N_REQ requesters. Accepts operand pairs over valid/ready, issues each job to the engine with a start pulse, and routes the result back to the owning port. Zero operands are resolved locally, because the engine never terminates on them. A watchdog aborts hung jobs. Sits between the Avalon slave front-ends and the shared GCD datapath.

Parameters:
N_REQ, 4, number of requester ports (2..8)
W, 32, operand/result width
TIMEOUT, 4096, max cycles in WAIT before abort (>=2)

Ports:
csi_clk  in  1  clock
rsi_reset  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-port job request
req_a  in  N_REQ*W  operand A, port i at [i*W +: W]
req_b  in  N_REQ*W  operand B, same packing
req_ready  out  N_REQ  per-port accept (one-hot or zero)
rsp_valid  out  N_REQ  per-port result strobe, 1 cycle
rsp_data  out  N_REQ*W  per-port result, held until that port's next response
rsp_err  out  N_REQ  per-port timeout flag, qualified by rsp_valid
eng_start  out  1  engine start pulse, 1 cycle
eng_a  out  W  engine operand A, stable from eng_start until job ends
eng_b  out  W  engine operand B
eng_abort  out  1  engine abort pulse, 1 cycle
eng_done  in  1  engine completion pulse
eng_result  in  W  engine result, valid with eng_done
busy  out  1  state != IDLE
owner  out  clog2(N_REQ)  port currently being served (last granted port when IDLE)

Behaviour:
- Reset, async, any state: state=IDLE; rr pointer=N_REQ-1 so port 0 has first priority. All outputs 0: req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_abort, eng_a, eng_b, owner. Timer=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant g = first port with req_valid, searching from rr pointer+1 with wrap. req_ready[g] is combinational: high only in IDLE, only for g. On transfer (valid&&ready), capture a, b, g and set owner=g.
  - If a==0 or b==0: result = a|b (gcd(0,x)=x; gcd(0,0)=0), go to RESP. No eng_start is issued.
  - Otherwise: go to ISSUE.
- ISSUE: eng_start=1 for exactly 1 cycle; eng_a/eng_b driven from capture regs; timer cleared; go to WAIT.
- WAIT: timer increments each cycle.
  - eng_done=1: capture eng_result, err=0, go to RESP.
  - Otherwise, if timer reaches TIMEOUT-1: eng_abort=1 for 1 cycle, result=0, err=1, go to RESP.
  - eng_done in the same cycle as expiry: done wins, no abort.
- RESP: rsp_valid[g]=1 and rsp_err[g]=err for 1 cycle; rsp_data[g] updated (other ports' data untouched); rr pointer=g; go to IDLE.
- Latency: accept at cycle T.
  - Zero path: rsp_valid at T+1.
  - Normal path: eng_start at T+1; eng_done at cycle D gives rsp_valid at D+1.
  - Timeout: rsp_valid exactly TIMEOUT+1 cycles after eng_start.
- No request is accepted in ISSUE/WAIT/RESP. Back-to-back service: next accept is possible the cycle after RESP.
- eng_done outside WAIT (stale after abort or reset) is ignored.
- Requesters must hold req_valid and operands stable until req_ready. Dropping valid before grant is legal and no job is created.
- Fairness: a port continuously requesting waits at most N_REQ-1 jobs.

Test Plan:
- Port 1 requests a=48, b=18; engine model returns done after 5 cycles with 6 -> single eng_start with eng_a=48, eng_b=18; rsp_valid[1] with rsp_data=6, rsp_err=0; busy low afterward.
- Port 2 requests a=0, b=7 -> req_ready[2] at T, rsp_valid[2] at T+1 with data 7; eng_start never asserted. Repeat with (0,0) -> data 0.
- All 4 ports assert valid together after reset and re-request on completion -> grant order 0,1,2,3,0; each port receives its own result; no port is served twice in a row while others wait.
- Engine model never returns done, TIMEOUT=16 -> eng_abort pulse at eng_start+16; rsp_err=1 and rsp_data=0 one cycle later. A late eng_done afterward is ignored and produces no rsp_valid.
- eng_done coincides with the final timeout cycle -> normal result, rsp_err=0, no eng_abort.
- Assert rsi_reset mid-WAIT, then release -> all outputs 0 immediately. The next request from ports 1 and 0 together grants port 0 first. A stale eng_done after reset is ignored.
